// File: rtl/rom_mult_pkg.sv
// Shared types and constants for the ROM-based 2N x 2N multiplier sequencer.
package rom_mult_pkg;

    typedef enum logic [1:0] {IDLE, LOOK, HOLD} state_t;

    localparam int unsigned LOOKUPS  = 4;
    localparam logic [1:0]  LAST_IDX = 2'(LOOKUPS - 1);

    // Left shift applied to the partial product of lookup idx.
    function automatic int unsigned pp_shift(input int unsigned n, input logic [1:0] idx);
        int unsigned r_shift;
        case (idx)
            2'd0:    r_shift = 0;
            2'd1:    r_shift = n;
            2'd2:    r_shift = n;
            default: r_shift = 2 * n;
        endcase
        return r_shift;
    endfunction

endpackage

// File: rtl/rom_mult_pp_accum.sv
// Partial-product accumulator: aligns one ROM lookup by its idx and adds it to acc.
module rom_mult_pp_accum
    import rom_mult_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [1:0]     i_idx,
    input  logic [2*N-1:0] i_rom_data,
    input  logic [4*N-1:0] i_acc,
    output logic [4*N-1:0] o_acc
);

    logic [4*N-1:0] w_term;

    always_comb begin
        w_term = {{(2*N){1'b0}}, i_rom_data} << pp_shift(N, i_idx);
        o_acc  = i_acc + w_term;
    end

endmodule

// File: rtl/rom_mult_sequencer.sv
// Sequences four N x N ROM lookups to form a 2N x 2N unsigned product, with
// valid/ready handshakes on both sides and an optional zero-operand shortcut.
module rom_mult_sequencer
    import rom_mult_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] op_a,
    input  logic [2*N-1:0] op_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*N-1:0] product,
    output logic           busy,
    output logic [2*N-1:0] rom_address,
    output logic           rom_en,
    output logic           rom_read_en,
    input  logic [2*N-1:0] rom_data
);

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [4*N-1:0] r_acc;
    logic [2*N-1:0] r_a;
    logic [2*N-1:0] r_b;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [4*N-1:0] r_product;
    logic           r_rom_en;
    logic [2*N-1:0] r_rom_address;

    logic [4*N-1:0] w_acc_next;
    logic [1:0]     w_next_idx;
    logic [N-1:0]   w_a_half;
    logic [N-1:0]   w_b_half;
    logic           w_zero_op;

    rom_mult_pp_accum #(
        .N (N)
    ) u_pp_accum (
        .i_idx      (r_idx),
        .i_rom_data (rom_data),
        .i_acc      (r_acc),
        .o_acc      (w_acc_next)
    );

    // idx bit 1 picks the high half of a, idx bit 0 the high half of b.
    always_comb begin
        w_next_idx = r_idx + 2'd1;
        w_a_half   = w_next_idx[1] ? r_a[2*N-1:N] : r_a[N-1:0];
        w_b_half   = w_next_idx[0] ? r_b[2*N-1:N] : r_b[N-1:0];
        w_zero_op  = EARLY_ZERO && ((op_a == '0) || (op_b == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_acc         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_product     <= '0;
            r_rom_en      <= 1'b0;
            r_rom_address <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        if (w_zero_op) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_product   <= '0;
                        end else begin
                            r_state       <= LOOK;
                            r_rom_en      <= 1'b1;
                            r_rom_address <= {op_a[N-1:0], op_b[N-1:0]};
                        end
                    end
                end
                LOOK: begin
                    r_acc <= w_acc_next;
                    r_idx <= w_next_idx;
                    if (r_idx == LAST_IDX) begin
                        r_state       <= HOLD;
                        r_rom_en      <= 1'b0;
                        r_rom_address <= '0;
                        r_out_valid   <= 1'b1;
                        r_product     <= w_acc_next;
                    end else begin
                        r_rom_address <= {w_a_half, w_b_half};
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign product     = r_product;
    assign busy        = (r_state != IDLE);
    assign rom_address = r_rom_address;
    assign rom_en      = r_rom_en;
    assign rom_read_en = r_rom_en;

endmodule

// File: tb/tb_rom_mult_sequencer.sv
// Bench for rom_mult_sequencer: directed and random operand pairs checked against plain
// multiplication and the lookup order of operand halves, on EARLY_ZERO=1 and =0 instances.
module tb_rom_mult_sequencer;

    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: EARLY_ZERO=1. Instance Z: EARLY_ZERO=0.
    logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic           a_rom_en, a_rom_read_en;
    logic [2*N-1:0] a_op_a, a_op_b, a_rom_address, a_rom_data;
    logic [4*N-1:0] a_product;
    logic           z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic           z_rom_en, z_rom_read_en;
    logic [2*N-1:0] z_op_a, z_op_b, z_rom_address, z_rom_data;
    logic [4*N-1:0] z_product;

    assign a_rom_data = {{N{1'b0}}, a_rom_address[2*N-1:N]} * {{N{1'b0}}, a_rom_address[N-1:0]};
    assign z_rom_data = {{N{1'b0}}, z_rom_address[2*N-1:N]} * {{N{1'b0}}, z_rom_address[N-1:0]};

    rom_mult_sequencer #(.N(N), .EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op_a(a_op_a), .op_b(a_op_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .product(a_product), .busy(a_busy), .rom_address(a_rom_address), .rom_en(a_rom_en),
        .rom_read_en(a_rom_read_en), .rom_data(a_rom_data)
    );

    rom_mult_sequencer #(.N(N), .EARLY_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .op_a(z_op_a), .op_b(z_op_b), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .product(z_product), .busy(z_busy), .rom_address(z_rom_address), .rom_en(z_rom_en),
        .rom_read_en(z_rom_read_en), .rom_data(z_rom_data)
    );

    bit             sel = 1'b0;
    logic           m_in_ready, m_out_valid, m_busy, m_rom_en, m_rom_read_en;
    logic [2*N-1:0] m_rom_address;
    logic [4*N-1:0] m_product;

    always_comb begin
        m_in_ready    = sel ? z_in_ready    : a_in_ready;
        m_out_valid   = sel ? z_out_valid   : a_out_valid;
        m_busy        = sel ? z_busy        : a_busy;
        m_rom_en      = sel ? z_rom_en      : a_rom_en;
        m_rom_read_en = sel ? z_rom_read_en : a_rom_read_en;
        m_rom_address = sel ? z_rom_address : a_rom_address;
        m_product     = sel ? z_product     : a_product;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2*N-1:0] oa, input logic [2*N-1:0] ob,
                         input logic rdy);
        if (sel) begin
            z_in_valid = v; z_op_a = oa; z_op_b = ob; z_out_ready = rdy;
        end else begin
            a_in_valid = v; a_op_a = oa; a_op_b = ob; a_out_ready = rdy;
        end
    endtask

    // Lookup k pairs a-half (high for k>=2) with b-half (high for odd k).
    function automatic logic [2*N-1:0] exp_addr(input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                                                input int k);
        logic [N-1:0] ah, bh;
        ah = (k >= 2)     ? a[2*N-1:N] : a[N-1:0];
        bh = (k % 2 == 1) ? b[2*N-1:N] : b[N-1:0];
        return {ah, bh};
    endfunction

    task automatic run_op(input logic [2*N-1:0] a, input logic [2*N-1:0] b, input int hold,
                          input bit ivpulse);
        int guard, lat, nlk, exp_lk;
        bit zp;
        logic [4*N-1:0] prod_exp;
        logic [2*N-1:0] ra, rb;
        zp       = !sel && (a == 0 || b == 0);
        exp_lk   = zp ? 0 : 4;
        prod_exp = {{(2*N){1'b0}}, a} * {{(2*N){1'b0}}, b};
        guard = 0;
        while (!m_in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("in_ready_idle", 32'(m_in_ready), 1);
        drive(1'b1, a, b, 1'b0);
        tick();
        ra = (2*N)'($urandom);
        rb = (2*N)'($urandom);
        drive(1'b0, ra, rb, 1'b0);
        lat = 0;
        nlk = 0;
        while (!m_out_valid && lat < 12) begin
            chk("busy_run", 32'(m_busy), 1);
            chk("in_ready_run", 32'(m_in_ready), 0);
            if (m_rom_en) begin
                chk("rom_addr", 32'(m_rom_address), 32'(exp_addr(a, b, nlk)));
                chk("rom_read_en", 32'(m_rom_read_en), 1);
                nlk++;
            end
            tick();
            lat++;
        end
        chk("lookups", nlk, exp_lk);
        chk("latency_edges", lat, zp ? 0 : 4);
        chk("out_valid", 32'(m_out_valid), 1);
        chk("product", 32'(m_product), 32'(prod_exp));
        chk("rom_en_hold", 32'(m_rom_en), 0);
        for (int h = 0; h < hold; h++) begin
            if (ivpulse) begin
                ra = (2*N)'($urandom);
                rb = (2*N)'($urandom);
                drive(1'b1, ra, rb, 1'b0);
            end
            tick();
            chk("hold_product", 32'(m_product), 32'(prod_exp));
            chk("hold_valid", 32'(m_out_valid), 1);
            chk("hold_in_ready", 32'(m_in_ready), 0);
        end
        drive(1'b0, a, b, 1'b1);
        tick();
        drive(1'b0, a, b, 1'b0);
        chk("valid_drop", 32'(m_out_valid), 0);
        chk("in_ready_back", 32'(m_in_ready), 1);
        chk("busy_idle", 32'(m_busy), 0);
        chk("product_kept", 32'(m_product), 32'(prod_exp));
        tick();
        chk("single_delivery", 32'(m_out_valid), 0);
    endtask

    initial begin
        logic [2*N-1:0] ra, rb;
        int t, nacc, npop, hold;
        int acc_t [2];
        logic [4*N-1:0] pops [2];
        a_in_valid = 0; a_op_a = 0; a_op_b = 0; a_out_ready = 0;
        z_in_valid = 0; z_op_a = 0; z_op_b = 0; z_out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_product", 32'(a_product), 0);
        chk("rst_rom_en", 32'(a_rom_en), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        sel = 1'b0;
        run_op(4'd15, 4'd15, 0, 1'b0);
        run_op(4'd9, 4'd6, 0, 1'b0);
        run_op(4'd0, 4'd13, 0, 1'b0);
        run_op(4'd7, 4'd11, 3, 1'b1);

        // Reset while the third lookup is being presented.
        drive(1'b1, 4'd9, 4'd6, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        chk("addr_idx2", 32'(a_rom_address), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(a_in_ready), 1);
        chk("mid_rst_out_valid", 32'(a_out_valid), 0);
        chk("mid_rst_product", 32'(a_product), 0);
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_rom_en", 32'(a_rom_en), 0);
        chk("mid_rst_rom_read_en", 32'(a_rom_read_en), 0);
        chk("mid_rst_rom_addr", 32'(a_rom_address), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_op(4'd3, 4'd5, 0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        nacc = 0;
        npop = 0;
        acc_t[0] = 0; acc_t[1] = 0;
        pops[0] = '0; pops[1] = '0;
        drive(1'b1, 4'd12, 4'd12, 1'b1);
        for (t = 0; t < 16; t++) begin
            if (a_out_valid) chk("no_bypass", 32'(a_in_ready), 0);
            if (a_out_valid && npop < 2) begin
                pops[npop] = a_product;
                npop++;
            end
            if (a_in_ready && a_in_valid && nacc < 2) begin
                acc_t[nacc] = t;
                nacc++;
            end
            tick();
            if (nacc == 1) drive(1'b1, 4'd4, 4'd4, 1'b1);
            if (nacc == 2) drive(1'b0, 4'd4, 4'd4, 1'b1);
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("b2b_accepts", nacc, 2);
        chk("b2b_pops", npop, 2);
        chk("b2b_gap", acc_t[1] - acc_t[0], 6);
        chk("b2b_prod0", 32'(pops[0]), 144);
        chk("b2b_prod1", 32'(pops[1]), 16);
        tick();

        for (int i = 0; i < 16; i++) begin
            ra = (2*N)'($urandom);
            rb = (2*N)'($urandom);
            if ($urandom_range(3) == 0) ra = '0;
            if ($urandom_range(3) == 0) rb = '0;
            hold = int'($urandom_range(2));
            run_op(ra, rb, hold, 1'($urandom));
        end

        sel = 1'b1;
        run_op(4'd0, 4'd13, 0, 1'b0);
        run_op(4'd9, 4'd0, 1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = (2*N)'($urandom);
            rb = (2*N)'($urandom);
            run_op(ra, rb, int'($urandom_range(2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
